stack_arb: RTL

- Round-robin arbiter and sequencer that shares one single-push/single-pop LIFO stack instance among REQ requesters.
- Each cycle it selects at most one push or pop request, drives the stack's active-low push_/pop_ strobes, and returns a registered acknowledge with pop data and an underflow flag one cycle later.
- Tracks stack occupancy, withholds pushes while the stack reports busy, and forwards flush.

---
 rtl/stack_arb.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/stack_arb.sv
// stack_arb: round-robin arbiter/sequencer that shares one single-push/
// single-pop LIFO stack among REQ requesters.
//
// Each cycle at most one pending request wins. The winner's push or pop is
// issued to the stack in that same cycle through the active-low strobes. A
// registered acknowledge follows one cycle later. For a pop, the acknowledge
// carries the popped data and an underflow flag.
//
// Ports
//   clk, reset_         clock, asynchronous active-low reset
//   flush_              active-low clear, forwarded to the stack; no grants
//   req_[REQ]           per-requester request (active low), held until ack_
//   req_push[REQ]       per-requester op: 1 = push, 0 = pop
//   req_wd[REQ][DATA]   per-requester push data
//   ack_[REQ]           registered one-hot-low acknowledge
//   ack_rd, ack_err     pop data / underflow flag, valid with ack_
//   level               stack occupancy as tracked by the arbiter
//   stk_flush_, stk_push_, stk_wd, stk_pop_   stack controls
//   stk_rd, stk_v, stk_busy                   stack top data / valid / busy
module stack_arb #(
  parameter int unsigned DATA  = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned REQ   = 4
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     flush_,
  input  logic [REQ-1:0]           req_,
  input  logic [REQ-1:0]           req_push,
  input  logic [REQ-1:0][DATA-1:0] req_wd,
  output logic [REQ-1:0]           ack_,
  output logic [DATA-1:0]          ack_rd,
  output logic                     ack_err,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     stk_flush_,
  output logic                     stk_push_,
  output logic [DATA-1:0]          stk_wd,
  output logic                     stk_pop_,
  input  logic [DATA-1:0]          stk_rd,
  input  logic                     stk_v,
  input  logic                     stk_busy
);

  localparam int unsigned PW = $clog2(REQ);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [PW-1:0]   rr_q, rr_d;
  logic            mask_v_q, mask_v_d;
  logic [PW-1:0]   mask_idx_q, mask_idx_d;
  logic [LW-1:0]   level_q, level_d;
  logic [REQ-1:0]  ack_q, ack_d;
  logic [DATA-1:0] ack_rd_q, ack_rd_d;
  logic            ack_err_q, ack_err_d;

  logic [REQ-1:0]  elig;
  logic            grant;
  logic [PW-1:0]   win;
  logic            push_go, pop_go;
  logic [PW:0]     sum;
  logic [PW:0]     nxt;

  // A push is withheld while the stack is full or busy. Pops always go:
  // the stack clamps its own pointer on underflow.
  always_comb begin
    elig = '0;
    for (int unsigned i = 0; i < REQ; i++) begin
      elig[i] = ~req_[i]
              & ~(mask_v_q && (mask_idx_q == PW'(i)))
              & (~req_push[i] | (~stk_busy & (level_q < LW'(DEPTH))))
              & flush_;
    end
  end

  // Search starting at rr_q, ascending with wrap-around. The first eligible
  // requester wins.
  always_comb begin
    grant = 1'b0;
    win   = '0;
    sum   = '0;
    for (int unsigned k = 0; k < REQ; k++) begin
      sum = {1'b0, rr_q} + (PW+1)'(k);
      if (sum >= (PW+1)'(REQ)) sum = sum - (PW+1)'(REQ);
      if (!grant && elig[sum[PW-1:0]]) begin
        grant = 1'b1;
        win   = sum[PW-1:0];
      end
    end
  end

  // Strobes are gated by reset_ so the stack sees nothing while in reset.
  always_comb begin
    push_go    = grant & req_push[win] & reset_;
    pop_go     = grant & ~req_push[win] & reset_;
    stk_push_  = ~push_go;
    stk_pop_   = ~pop_go;
    stk_wd     = push_go ? req_wd[win] : '0;
    stk_flush_ = flush_;
  end

  always_comb begin
    rr_d       = rr_q;
    mask_v_d   = mask_v_q;
    mask_idx_d = mask_idx_q;
    level_d    = level_q;
    ack_d      = '1;
    ack_rd_d   = '0;
    ack_err_d  = 1'b0;
    nxt        = {1'b0, win} + (PW+1)'(1);
    if (nxt >= (PW+1)'(REQ)) nxt = '0;

    if (!flush_) begin
      // Flush empties the stack. The pointer and the mask are left as they were.
      level_d = '0;
    end else begin
      mask_v_d   = grant;
      mask_idx_d = win;
      if (grant) begin
        rr_d       = nxt[PW-1:0];
        ack_d[win] = 1'b0;
        if (req_push[win]) begin
          if (level_q != LW'(DEPTH)) level_d = level_q + LW'(1);
        end else begin
          ack_rd_d  = stk_rd;
          ack_err_d = ~stk_v;
          if (level_q != '0) level_d = level_q - LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      rr_q       <= '0;
      mask_v_q   <= 1'b0;
      mask_idx_q <= '0;
      level_q    <= '0;
      ack_q      <= '1;
      ack_rd_q   <= '0;
      ack_err_q  <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      mask_v_q   <= mask_v_d;
      mask_idx_q <= mask_idx_d;
      level_q    <= level_d;
      ack_q      <= ack_d;
      ack_rd_q   <= ack_rd_d;
      ack_err_q  <= ack_err_d;
    end
  end

  assign ack_    = ack_q;
  assign ack_rd  = ack_rd_q;
  assign ack_err = ack_err_q;
  assign level   = level_q;

endmodule
